// File: rtl/sync_rr_arbiter.sv
// sync_rr_arbiter: registered round-robin arbiter with hold-time preemption
module sync_rr_arbiter #(
  parameter int REQUESTORS = 4,
  parameter int MAX_HOLD = 4,
  localparam int IW = (REQUESTORS > 2) ? $clog2(REQUESTORS) : 1,
  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REQUESTORS-1:0] request,
  output logic [REQUESTORS-1:0] grant,
  output logic                  grant_valid,
  output logic [IW-1:0]         grant_idx
);
  logic [IW-1:0] ptr, ptr_n, base, win, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [REQUESTORS-1:0] mask, grant_n;
  logic found, hold, full;
  always_comb begin
    base = grant_valid ? grant_idx : ptr;
    mask = request & ~grant;
    found = 1'b0;
    win = '0;
    for (int k = 1; k <= REQUESTORS; k++) begin
      int j;
      j = (int'(base) + k) % REQUESTORS;
      if (!found && mask[j]) begin
        found = 1'b1;
        win = IW'(j);
      end
    end
  end
  assign hold = |(request & grant);
  assign full = (MAX_HOLD != 0) && (cnt == CW'(MAX_HOLD));
  // The owner leaves on release or preemption; otherwise only the counter moves.
  always_comb begin
    ptr_n = ptr;
    grant_n = grant;
    idx_n = grant_idx;
    cnt_n = cnt;
    if (!hold || (|mask && full)) begin
      ptr_n = base;
      grant_n = found ? (REQUESTORS'(1) << win) : '0;
      idx_n = found ? win : '0;
      cnt_n = found ? CW'(1) : '0;
    end else if (cnt != CW'(MAX_HOLD)) begin
      cnt_n = cnt + CW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= IW'(REQUESTORS - 1);
      cnt <= '0;
      grant <= '0;
      grant_idx <= '0;
      grant_valid <= 1'b0;
    end else begin
      ptr <= ptr_n;
      cnt <= cnt_n;
      grant <= grant_n;
      grant_idx <= idx_n;
      grant_valid <= |grant_n;
    end
  end
endmodule

// File: doc/sync_rr_arbiter.md
Name: sync_rr_arbiter

Overview:
- Clocked round-robin arbiter with grant tenure limiting for up to REQUESTORS level-sensitive requesters sharing one resource.
- Grants are registered: they change only on clk edges, so asynchronous request glitches between edges are ignored.
- Enforces fair rotation and bounds each owner's continuous tenure when other requesters are waiting.
- Sits between requesting user logic and the shared resource; the one-hot grant drives the resource mux/enable directly.

Parameters:
- REQUESTORS, 4, number of requesters; must be >= 2.
- MAX_HOLD, 4, maximum consecutive cycles one owner keeps the grant while another request is pending; 0 = unlimited (release-only handoff).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- request  input  REQUESTORS  level request per requester; bit i high = requester i wants the resource.
- grant  output  REQUESTORS  registered one-hot grant, or all zero.
- grant_valid  output  1  registered; high when grant is non-zero.
- grant_idx  output  max(1,$clog2(REQUESTORS))  registered binary index of the owner; 0 when grant_valid is low.

Behaviour:
- Reset (rst high at an edge):
  - grant = 0, grant_valid = 0, grant_idx = 0.
  - Priority pointer ptr = REQUESTORS-1, so requester 0 has top priority after reset.
  - Hold counter cnt = 0.
  - rst dominates all other activity, including mid-grant: the grant drops on that edge with no handoff.
- State:
  - IDLE (grant_valid = 0) or OWNED(owner, cnt).
  - cnt width $clog2(MAX_HOLD+1), minimum 1; it saturates at MAX_HOLD.
- Round-robin search:
  - Scans request bits ptr+1, ptr+2, ... modulo REQUESTORS.
  - The first set bit wins; the scan wraps from REQUESTORS-1 to 0.
- IDLE, each edge:
  - request == 0: stay IDLE.
  - Otherwise: grant the search winner, enter OWNED, cnt = 1.
  - Latency: a request sampled at edge N is visible on grant after edge N (one-cycle registered latency).
- OWNED, each edge, evaluated in priority order:
  - (a) request[owner] low (release):
    - ptr = owner.
    - Search the remaining requests. Winner found: hand off on the same edge with no idle gap, cnt = 1. No winner: go to IDLE.
  - (b) request[owner] high, another request bit set, and MAX_HOLD != 0 and cnt == MAX_HOLD (preemption):
    - ptr = owner; the search excludes owner, so the preempted owner is last in priority.
    - Grant the winner, cnt = 1. The preempted requester keeps requesting and is re-granted in rotation.
  - (c) otherwise: keep owner, cnt = min(cnt+1, MAX_HOLD).
    - A sole requester is never preempted, however long it holds.
- Invariants:
  - grant is always one-hot or zero.
  - grant bit i is set only if request[i] was high at the edge that set it.
  - grant_idx and grant_valid are consistent with grant in the same cycle.
  - No requester waits more than (REQUESTORS-1)*MAX_HOLD cycles once its request is stable (MAX_HOLD != 0).
- ptr is updated only on a release or preemption, never while holding. In IDLE, ptr keeps the last owner, so rotation continues across idle periods.

Test Plan:
1. Reset, then request=4'b0001 for 3 cycles, then 4'b0000 -> grant=0000 in the reset cycle; grant=0001, grant_idx=0, grant_valid=1 from the edge after the request; grant=0000 one edge after the request drops.
2. After reset, request=4'b0011 applied simultaneously, then 4'b0010 -> grant=0001 first (ptr=3); on the edge after bit 0 drops, grant=0010 with no zero cycle between.
3. MAX_HOLD=4, request=4'b0011 held 20 cycles -> grant alternates 0001 x4 cycles, 0010 x4, 0001 x4, ...; grant_idx toggles 0/1 with the same period.
4. Single requester request=4'b0100 held 10 cycles -> grant=0100, grant_idx=2 throughout; no preemption.
5. Wrap-around: requester 3 owns (grant=1000) while request=4'b1101; bit 3 drops -> next edge grant=0001 (scan 0 after 3); then bit 0 drops -> grant=0100.
6. Reset mid-grant: grant=0010, assert rst for one edge with request=4'b0011 held -> grant=0000 for that cycle; on the next edge grant=0001 (ptr reset to 3).
